// File: rtl/cp0_regfile.sv
// CP0 architectural register file: commits exception/ERET side effects and MTC0 writes,
// runs the Count/Compare timer and produces the registered interrupt-pending vector.
package cp0_pkg;

  typedef struct packed {
    logic        flush;
    logic        eret;
    logic [4:0]  code;
    logic        delayslot;
    logic [31:0] cur_pc;
    logic [31:0] extra;
  } ExceptReq_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } CP0RegWriteReq_t;

  typedef struct packed {
    logic [31:0] bad_vaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] error_epc;
  } CP0Regs_t;

  localparam logic [4:0] REG_BADVADDR  = 5'd8;
  localparam logic [4:0] REG_COUNT     = 5'd9;
  localparam logic [4:0] REG_COMPARE   = 5'd11;
  localparam logic [4:0] REG_STATUS    = 5'd12;
  localparam logic [4:0] REG_CAUSE     = 5'd13;
  localparam logic [4:0] REG_EPC       = 5'd14;
  localparam logic [4:0] REG_ERROR_EPC = 5'd30;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] STATUS_MASK  = 32'h1040_FF17;
  localparam logic [31:0] CAUSE_MASK   = 32'h0080_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;

endpackage

module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  ExceptReq_t      except_req,
  input  CP0RegWriteReq_t wb_cp0_reg_wr,
  input  logic [5:0]      hw_int,
  output CP0Regs_t        cp0_regs,
  output logic [7:0]      interrupt_flag,
  output logic            timer_int
);

  localparam int STATUS_EXL = 1;
  localparam int STATUS_ERL = 2;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;

  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] error_epc_q, error_epc_d;
  logic        phase_q, phase_d;
  logic [7:0]  int_flag_q, int_flag_d;

  logic        tick;
  logic        ti;
  logic        mtc0;
  logic        addr_exc;

  always_comb begin
    bad_vaddr_d = bad_vaddr_q;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    error_epc_d = error_epc_q;

    // Hardware step: Count advance and sticky TI, compared against the post-increment value
    tick    = (COUNT_DIV == 1) ? 1'b1 : phase_q;
    count_d = count_q + {31'd0, tick};
    phase_d = ~phase_q;
    ti      = cause_q[CAUSE_TI] | (count_d == compare_q);

    mtc0 = wb_cp0_reg_wr.we && (wb_cp0_reg_wr.sel == 3'd0);
    if (mtc0) begin
      case (wb_cp0_reg_wr.waddr)
        REG_COUNT: begin
          count_d = wb_cp0_reg_wr.wdata;
          phase_d = 1'b0;
        end
        REG_COMPARE: begin
          compare_d = wb_cp0_reg_wr.wdata;
          ti        = 1'b0;
        end
        REG_STATUS:    status_d    = (wb_cp0_reg_wr.wdata & STATUS_MASK) | (status_q & ~STATUS_MASK);
        REG_CAUSE:     cause_d     = (wb_cp0_reg_wr.wdata & CAUSE_MASK) | (cause_q & ~CAUSE_MASK);
        REG_EPC:       epc_d       = wb_cp0_reg_wr.wdata;
        REG_ERROR_EPC: error_epc_d = wb_cp0_reg_wr.wdata;
        default: ;
      endcase
    end

    // IP[7:2] and TI are outside the Cause write mask, so they can be placed after the merge
    cause_d[CAUSE_TI] = ti;
    cause_d[15:10]    = {hw_int[5] | ti, hw_int[4:0]};

    addr_exc = (except_req.code == EXC_ADEL) || (except_req.code == EXC_ADES) ||
               (except_req.code == EXC_TLBL) || (except_req.code == EXC_TLBS) ||
               (except_req.code == EXC_MOD);

    if (except_req.flush) begin
      if (except_req.eret) begin
        if (status_q[STATUS_ERL]) status_d[STATUS_ERL] = 1'b0;
        else                      status_d[STATUS_EXL] = 1'b0;
      end else begin
        if (!status_q[STATUS_EXL]) begin
          epc_d             = except_req.delayslot ? except_req.cur_pc - 32'd4 : except_req.cur_pc;
          cause_d[CAUSE_BD] = except_req.delayslot;
        end
        status_d[STATUS_EXL] = 1'b1;
        cause_d[6:2]         = except_req.code;
        cause_d[29:28]       = (except_req.code == EXC_CPU) ? except_req.extra[1:0] : 2'b00;
        if (addr_exc) bad_vaddr_d = except_req.extra;
      end
    end

    int_flag_d = cause_d[15:8] & status_d[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_vaddr_q <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      status_q    <= STATUS_RESET;
      cause_q     <= '0;
      epc_q       <= '0;
      error_epc_q <= '0;
      phase_q     <= 1'b0;
      int_flag_q  <= '0;
    end else begin
      bad_vaddr_q <= bad_vaddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      error_epc_q <= error_epc_d;
      phase_q     <= phase_d;
      int_flag_q  <= int_flag_d;
    end
  end

  assign cp0_regs.bad_vaddr = bad_vaddr_q;
  assign cp0_regs.count     = count_q;
  assign cp0_regs.compare   = compare_q;
  assign cp0_regs.status    = status_q;
  assign cp0_regs.cause     = cause_q;
  assign cp0_regs.epc       = epc_q;
  assign cp0_regs.error_epc = error_epc_q;
  assign interrupt_flag     = int_flag_q;
  assign timer_int          = cause_q[CAUSE_TI];

endmodule
